// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a five-stage pipeline: tracks in-flight destinations in EX/MEM/WB
// and produces EX operand forwarding selects, the load-use stall and taken-branch flushes.
module pipeline_hazard_ctrl #(
   parameter int AW      = 5,
   parameter int CNT_W   = 16,
   parameter bit ZERO_HW = 1'b1
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             id_valid,
   input  logic [AW-1:0]    id_rs,
   input  logic [AW-1:0]    id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic [AW-1:0]    id_dst,
   input  logic             id_RegWrite,
   input  logic             id_MemRead,
   input  logic             PCSrc_MEM,
   output logic             Stall,
   output logic             Flush_IFID,
   output logic             Flush_IDEX,
   output logic             Flush_EXMEM,
   output logic [1:0]       ForwardA,
   output logic [1:0]       ForwardB,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   // Register 0 never counts as a producer when it is hardwired.
   function automatic logic dst_live(input logic [AW-1:0] r);
      return (!ZERO_HW) || (r != '0);
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // Youngest producer (MEM) wins over the older one (WB).
   function automatic logic [1:0] fwd_sel(
      input logic          ev,
      input logic [AW-1:0] src,
      input logic          mv,
      input logic          mrw,
      input logic [AW-1:0] mdst,
      input logic          wv,
      input logic          wrw,
      input logic [AW-1:0] wdst
   );
      if (!ev)                                              return 2'b00;
      else if (mv && mrw && dst_live(mdst) && mdst == src)  return 2'b10;
      else if (wv && wrw && dst_live(wdst) && wdst == src)  return 2'b01;
      else                                                  return 2'b00;
   endfunction

   logic             ex_v_q,   ex_v_d;
   logic [AW-1:0]    ex_rs_q,  ex_rs_d;
   logic [AW-1:0]    ex_rt_q,  ex_rt_d;
   logic [AW-1:0]    ex_dst_q, ex_dst_d;
   logic             ex_rw_q,  ex_rw_d;
   logic             ex_mr_q,  ex_mr_d;
   logic             mem_v_q,   mem_v_d;
   logic [AW-1:0]    mem_dst_q, mem_dst_d;
   logic             mem_rw_q,  mem_rw_d;
   logic             wb_v_q,   wb_v_d;
   logic [AW-1:0]    wb_dst_q, wb_dst_d;
   logic             wb_rw_q,  wb_rw_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic             load_use;
   logic             stall;
   logic             flush;
   logic [1:0]       fwd_a;
   logic [1:0]       fwd_b;

   // Hazard detection and forwarding; every output is held quiet while Rst is high.
   always_comb begin
      load_use = id_valid & ex_v_q & ex_mr_q & ex_rw_q & dst_live(ex_dst_q) &
                 ((id_uses_rs & (id_rs == ex_dst_q)) | (id_uses_rt & (id_rt == ex_dst_q)));
      stall    = load_use & ~PCSrc_MEM & ~Rst;
      flush    = PCSrc_MEM & ~Rst;
      fwd_a    = 2'b00;
      fwd_b    = 2'b00;
      if (!Rst) begin
         fwd_a = fwd_sel(ex_v_q, ex_rs_q, mem_v_q, mem_rw_q, mem_dst_q, wb_v_q, wb_rw_q, wb_dst_q);
         fwd_b = fwd_sel(ex_v_q, ex_rt_q, mem_v_q, mem_rw_q, mem_dst_q, wb_v_q, wb_rw_q, wb_dst_q);
      end
   end

   // Scoreboard advance: a flush squashes the EX->MEM move, stall or flush bubbles ID->EX.
   always_comb begin
      wb_v_d      = mem_v_q;
      wb_dst_d    = mem_dst_q;
      wb_rw_d     = mem_rw_q;
      mem_v_d     = ex_v_q & ~PCSrc_MEM;
      mem_dst_d   = ex_dst_q;
      mem_rw_d    = ex_rw_q;
      ex_v_d      = id_valid & ~stall & ~PCSrc_MEM;
      ex_rs_d     = id_rs;
      ex_rt_d     = id_rt;
      ex_dst_d    = id_dst;
      ex_rw_d     = id_RegWrite;
      ex_mr_d     = id_MemRead;
      stall_cnt_d = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
      flush_cnt_d = flush ? sat_inc(flush_cnt_q) : flush_cnt_q;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         ex_v_q      <= 1'b0;
         mem_v_q     <= 1'b0;
         wb_v_q      <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         ex_v_q      <= ex_v_d;
         mem_v_q     <= mem_v_d;
         wb_v_q      <= wb_v_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Slot payloads are only meaningful under their valid bit, so they carry no reset.
   always_ff @(posedge Clk) begin
      ex_rs_q   <= ex_rs_d;
      ex_rt_q   <= ex_rt_d;
      ex_dst_q  <= ex_dst_d;
      ex_rw_q   <= ex_rw_d;
      ex_mr_q   <= ex_mr_d;
      mem_dst_q <= mem_dst_d;
      mem_rw_q  <= mem_rw_d;
      wb_dst_q  <= wb_dst_d;
      wb_rw_q   <= wb_rw_d;
   end

   assign Stall       = stall;
   assign Flush_IFID  = flush;
   assign Flush_IDEX  = flush;
   assign Flush_EXMEM = flush;
   assign ForwardA    = fwd_a;
   assign ForwardB    = fwd_b;
   assign StallCount  = stall_cnt_q;
   assign FlushCount  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus randomized traffic
// checked against an instruction-queue reference model.
module tb_pipeline_hazard_ctrl;

   localparam int AW    = 5;
   localparam int CNT_W = 16;
   localparam int SAT_W = 3;

   logic             Clk = 1'b0;
   logic             Rst;
   logic             id_valid;
   logic [AW-1:0]    id_rs, id_rt, id_dst;
   logic             id_uses_rs, id_uses_rt, id_RegWrite, id_MemRead;
   logic             PCSrc_MEM;
   logic             Stall, Flush_IFID, Flush_IDEX, Flush_EXMEM;
   logic [1:0]       ForwardA, ForwardB;
   logic [CNT_W-1:0] StallCount, FlushCount;
   logic             s_Stall, s_Flush_IFID, s_Flush_IDEX, s_Flush_EXMEM;
   logic [1:0]       s_ForwardA, s_ForwardB;
   logic [SAT_W-1:0] s_StallCount, s_FlushCount;

   int total = 0;
   int bad   = 0;

   always #5 Clk = ~Clk;

   pipeline_hazard_ctrl #(.AW(AW), .CNT_W(CNT_W), .ZERO_HW(1'b1)) dut (
      .Clk(Clk), .Rst(Rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
      .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .PCSrc_MEM(PCSrc_MEM),
      .Stall(Stall), .Flush_IFID(Flush_IFID), .Flush_IDEX(Flush_IDEX),
      .Flush_EXMEM(Flush_EXMEM), .ForwardA(ForwardA), .ForwardB(ForwardB),
      .StallCount(StallCount), .FlushCount(FlushCount)
   );

   // Narrow-counter instance so saturation is reachable in a short run.
   pipeline_hazard_ctrl #(.AW(AW), .CNT_W(SAT_W), .ZERO_HW(1'b1)) dut_sat (
      .Clk(Clk), .Rst(Rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
      .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .PCSrc_MEM(PCSrc_MEM),
      .Stall(s_Stall), .Flush_IFID(s_Flush_IFID), .Flush_IDEX(s_Flush_IDEX),
      .Flush_EXMEM(s_Flush_EXMEM), .ForwardA(s_ForwardA), .ForwardB(s_ForwardB),
      .StallCount(s_StallCount), .FlushCount(s_FlushCount)
   );

   // Reference model: queue of in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB.
   typedef struct {
      bit       v;
      bit [4:0] rs;
      bit [4:0] rt;
      bit [4:0] dst;
      bit       rw;
      bit       mr;
   } instr_t;

   instr_t pipe[$];
   int     m_stalls;
   int     m_flushes;

   function automatic instr_t bubble();
      instr_t b;
      b.v = 0; b.rs = 0; b.rt = 0; b.dst = 0; b.rw = 0; b.mr = 0;
      return b;
   endfunction

   function automatic bit produces(instr_t p, bit [4:0] r);
      return p.v && p.rw && p.dst != 0 && p.dst == r;
   endfunction

   function automatic bit m_hazard();
      instr_t e;
      e = pipe[0];
      if (!id_valid || !e.v || !e.mr || !e.rw || e.dst == 0) return 0;
      return (id_uses_rs && id_rs == e.dst) || (id_uses_rt && id_rt == e.dst);
   endfunction

   function automatic bit m_stall();
      return !Rst && !PCSrc_MEM && m_hazard();
   endfunction

   function automatic bit m_flush();
      return !Rst && PCSrc_MEM;
   endfunction

   function automatic logic [1:0] m_fwd(bit [4:0] src);
      if (Rst || !pipe[0].v) return 2'b00;
      if (produces(pipe[1], src)) return 2'b10;
      if (produces(pipe[2], src)) return 2'b01;
      return 2'b00;
   endfunction

   function automatic int sat(int n, int w);
      int mx;
      mx = (1 << w) - 1;
      return (n > mx) ? mx : n;
   endfunction

   task automatic model_reset();
      pipe.delete();
      for (int i = 0; i < 3; i++) pipe.push_back(bubble());
      m_stalls  = 0;
      m_flushes = 0;
   endtask

   task automatic model_edge();
      instr_t nw;
      instr_t t;
      bit     st;
      if (Rst) begin
         model_reset();
         return;
      end
      st = m_stall();
      if (st) m_stalls++;
      if (PCSrc_MEM) m_flushes++;
      void'(pipe.pop_back());
      if (PCSrc_MEM) begin
         t = pipe[0];
         t.v = 0;
         pipe[0] = t;
      end
      nw.v = id_valid && !st && !PCSrc_MEM;
      nw.rs = id_rs; nw.rt = id_rt; nw.dst = id_dst;
      nw.rw = id_RegWrite; nw.mr = id_MemRead;
      pipe.push_front(nw);
   endtask

   task automatic tick();
      @(posedge Clk);
      model_edge();
      #1;
   endtask

   task automatic drive(input bit v, input bit [4:0] rs, input bit [4:0] rt,
                        input bit urs, input bit urt, input bit [4:0] dst,
                        input bit rw, input bit mr, input bit pc);
      id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
      id_dst = dst; id_RegWrite = rw; id_MemRead = mr; PCSrc_MEM = pc;
   endtask

   task automatic nop();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_reset();
      Rst = 1'b1;
      drive(1, 5, 5, 1, 1, 5, 1, 1, 1);
      @(negedge Clk);
      total++;
      if (Stall !== 1'b0 || Flush_IFID !== 1'b0 || Flush_IDEX !== 1'b0 || Flush_EXMEM !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctrl: stall=%b flush=%b%b%b required all 0", Stall, Flush_IFID, Flush_IDEX, Flush_EXMEM);
      end
      tick();
      tick();
      @(negedge Clk);
      total++;
      if (ForwardA !== 2'b00 || ForwardB !== 2'b00) begin
         bad++;
         $display("FAIL reset_fwd: A=%b B=%b required 00", ForwardA, ForwardB);
      end
      total++;
      if (StallCount !== '0 || FlushCount !== '0) begin
         bad++;
         $display("FAIL reset_cnt: stall=%0d flush=%0d required 0", StallCount, FlushCount);
      end
      Rst = 1'b0;
      nop();
      tick();
      @(negedge Clk);
      total++;
      if (Stall !== 1'b0 || ForwardA !== 2'b00 || ForwardB !== 2'b00) begin
         bad++;
         $display("FAIL after_reset: stall=%b A=%b B=%b required 0/00/00", Stall, ForwardA, ForwardB);
      end
   endtask

   task automatic test_forward_ex();
      drive(1, 1, 2, 1, 1, 3, 1, 0, 0);   // add $3
      tick();
      drive(1, 3, 4, 1, 1, 6, 1, 0, 0);   // sub reads $3
      tick();
      drive(1, 0, 3, 1, 1, 8, 1, 0, 0);   // reader of $3 on rt
      @(negedge Clk);
      total++;
      if (ForwardA !== 2'b10 || ForwardB !== 2'b00) begin
         bad++;
         $display("FAIL fwd_exmem: A=%b B=%b required 10 00", ForwardA, ForwardB);
      end
      tick();
      nop();
      @(negedge Clk);
      total++;
      if (ForwardB !== 2'b01 || ForwardA !== 2'b00) begin
         bad++;
         $display("FAIL fwd_memwb: A=%b B=%b required 00 01", ForwardA, ForwardB);
      end
      tick();
   endtask

   task automatic test_load_use();
      int c0;
      c0 = m_stalls;
      drive(1, 1, 0, 1, 0, 5, 1, 1, 0);   // lw $5
      tick();
      drive(1, 2, 5, 1, 1, 9, 1, 0, 0);   // reads $5 on rt
      @(negedge Clk);
      total++;
      if (Stall !== 1'b1) begin
         bad++;
         $display("FAIL load_use_stall: stall=%b required 1", Stall);
      end
      tick();
      @(negedge Clk);
      total++;
      if (Stall !== 1'b0 || ForwardA !== 2'b00 || ForwardB !== 2'b00) begin
         bad++;
         $display("FAIL bubble_cycle: stall=%b A=%b B=%b required 0 00 00", Stall, ForwardA, ForwardB);
      end
      total++;
      if (StallCount !== CNT_W'(c0 + 1)) begin
         bad++;
         $display("FAIL stall_count: got=%0d required=%0d", StallCount, c0 + 1);
      end
      tick();
      nop();
      @(negedge Clk);
      total++;
      if (ForwardB !== 2'b01) begin
         bad++;
         $display("FAIL load_fwd_b: got=%b required 01", ForwardB);
      end
      tick();
   endtask

   task automatic test_flush_priority();
      int f0;
      f0 = m_flushes;
      drive(1, 1, 0, 1, 0, 5, 1, 1, 0);   // lw $5
      tick();
      drive(1, 2, 5, 1, 1, 9, 1, 0, 1);   // hazard reader with taken branch
      @(negedge Clk);
      total++;
      if (Stall !== 1'b0 || Flush_IFID !== 1'b1 || Flush_IDEX !== 1'b1 || Flush_EXMEM !== 1'b1) begin
         bad++;
         $display("FAIL flush_prio: stall=%b flush=%b%b%b required 0 111", Stall, Flush_IFID, Flush_IDEX, Flush_EXMEM);
      end
      tick();
      drive(1, 5, 9, 1, 1, 10, 1, 0, 0);  // reads $5 and $9, both squashed
      @(negedge Clk);
      total++;
      if (FlushCount !== CNT_W'(f0 + 1) || Flush_IFID !== 1'b0) begin
         bad++;
         $display("FAIL flush_count: got=%0d flush=%b required=%0d 0", FlushCount, Flush_IFID, f0 + 1);
      end
      tick();
      nop();
      @(negedge Clk);
      total++;
      if (ForwardA !== 2'b00 || ForwardB !== 2'b00) begin
         bad++;
         $display("FAIL flushed_slots: A=%b B=%b required 00 00", ForwardA, ForwardB);
      end
      tick();
   endtask

   task automatic test_zero_reg();
      drive(1, 1, 2, 1, 1, 0, 1, 1, 0);   // load to $0
      tick();
      drive(1, 0, 0, 1, 1, 4, 1, 0, 0);
      @(negedge Clk);
      total++;
      if (Stall !== 1'b0) begin
         bad++;
         $display("FAIL zero_stall: stall=%b required 0", Stall);
      end
      tick();
      nop();
      @(negedge Clk);
      total++;
      if (ForwardA !== 2'b00 || ForwardB !== 2'b00) begin
         bad++;
         $display("FAIL zero_fwd: A=%b B=%b required 00 00", ForwardA, ForwardB);
      end
      tick();
   endtask

   task automatic test_mem_beats_wb();
      drive(1, 1, 2, 1, 1, 7, 1, 0, 0);
      tick();
      drive(1, 3, 4, 1, 1, 7, 1, 0, 0);
      tick();
      drive(1, 7, 7, 1, 1, 11, 1, 0, 0);
      tick();
      nop();
      @(negedge Clk);
      total++;
      if (ForwardA !== 2'b10 || ForwardB !== 2'b10) begin
         bad++;
         $display("FAIL mem_beats_wb: A=%b B=%b required 10 10", ForwardA, ForwardB);
      end
      tick();
   endtask

   task automatic test_saturation_and_reset();
      for (int i = 0; i < 10; i++) begin
         drive(1, 1, 0, 1, 0, 5, 1, 1, 0);
         tick();
         drive(1, 5, 2, 1, 1, 9, 0, 0, 0);
         tick();
      end
      @(negedge Clk);
      total++;
      if (s_StallCount !== {SAT_W{1'b1}}) begin
         bad++;
         $display("FAIL stall_saturate: got=%0d required=%0d", s_StallCount, (1 << SAT_W) - 1);
      end
      total++;
      if (StallCount !== CNT_W'(m_stalls)) begin
         bad++;
         $display("FAIL stall_count_wide: got=%0d required=%0d", StallCount, m_stalls);
      end
      drive(1, 1, 0, 1, 0, 5, 1, 1, 0);
      tick();
      drive(1, 5, 2, 1, 1, 9, 0, 0, 0);
      @(negedge Clk);
      total++;
      if (s_Stall !== 1'b1 || s_StallCount !== {SAT_W{1'b1}}) begin
         bad++;
         $display("FAIL sat_hold: stall=%b cnt=%0d required 1 %0d", s_Stall, s_StallCount, (1 << SAT_W) - 1);
      end
      Rst = 1'b1;
      tick();
      Rst = 1'b0;
      @(negedge Clk);
      total++;
      if (Stall !== 1'b0 || StallCount !== '0 || FlushCount !== '0 || s_StallCount !== '0) begin
         bad++;
         $display("FAIL reset_mid_stall: stall=%b cnt=%0d/%0d sat=%0d required 0 0/0 0",
                  Stall, StallCount, FlushCount, s_StallCount);
      end
      tick();
   endtask

   task automatic test_random();
      bit          e_st, e_fl;
      logic [1:0]  e_a, e_b;
      for (int n = 0; n < 400; n++) begin
         Rst = ($urandom_range(0, 49) == 0);
         drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               $urandom_range(0, 1), $urandom_range(0, 1), 5'($urandom_range(0, 3)),
               $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 7) == 0);
         @(negedge Clk);
         e_st = m_stall();
         e_fl = m_flush();
         e_a  = m_fwd(id_rs == id_rs ? pipe[0].rs : 5'd0);
         e_b  = m_fwd(pipe[0].rt);
         total++;
         if (Stall !== e_st || s_Stall !== e_st) begin
            bad++;
            $display("FAIL rnd_stall n=%0d: got=%b/%b required=%b", n, Stall, s_Stall, e_st);
         end
         total++;
         if (Flush_IFID !== e_fl || Flush_IDEX !== e_fl || Flush_EXMEM !== e_fl) begin
            bad++;
            $display("FAIL rnd_flush n=%0d: got=%b%b%b required=%b", n, Flush_IFID, Flush_IDEX, Flush_EXMEM, e_fl);
         end
         total++;
         if (ForwardA !== e_a || ForwardB !== e_b) begin
            bad++;
            $display("FAIL rnd_fwd n=%0d: A=%b B=%b required %b %b", n, ForwardA, ForwardB, e_a, e_b);
         end
         total++;
         if (StallCount !== CNT_W'(m_stalls) || FlushCount !== CNT_W'(m_flushes)) begin
            bad++;
            $display("FAIL rnd_cnt n=%0d: got=%0d/%0d required=%0d/%0d", n, StallCount, FlushCount, m_stalls, m_flushes);
         end
         total++;
         if (s_StallCount !== SAT_W'(sat(m_stalls, SAT_W)) || s_FlushCount !== SAT_W'(sat(m_flushes, SAT_W))) begin
            bad++;
            $display("FAIL rnd_sat n=%0d: got=%0d/%0d required=%0d/%0d", n, s_StallCount, s_FlushCount,
                     sat(m_stalls, SAT_W), sat(m_flushes, SAT_W));
         end
         tick();
      end
      Rst = 1'b0;
      nop();
   endtask

   initial begin
      model_reset();
      Rst = 1'b1;
      nop();
      test_reset();
      test_forward_ex();
      test_load_use();
      test_flush_priority();
      test_zero_reg();
      test_mem_beats_wb();
      test_saturation_and_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
